// File: rtl/mod_exp_ctrl.sv
// Square-and-multiply sequencer for a Montgomery product engine: skips leading zeros of the
// exponent, then issues x*x / x*M per remaining bit and a closing x*1, one op at a time.
module mod_exp_ctrl #(
    parameter int unsigned EBITS    = 1024,
    parameter int unsigned MP_COUNT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [EBITS-1:0] exp,
    input  logic             abort,
    output logic             mp_start,
    output logic [1:0]       mp_op,
    output logic [9:0]       mp_count,
    input  logic             mp_stop,
    output logic             busy,
    output logic             done,
    output logic             zero_exp,
    output logic [11:0]      op_total
);

    localparam int unsigned     IW      = $clog2(EBITS);
    localparam logic [IW-1:0]   IDX_TOP = IW'(EBITS - 1);
    localparam logic [9:0]      MPC10   = 10'(MP_COUNT);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_ISSUE, S_WAIT, S_FINAL, S_FWAIT, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OPXX = 2'd0,
        OPXM = 2'd1,
        OPX1 = 2'd2
    } op_t;

    state_t           state_q, state_d;
    logic [EBITS-1:0] e_q, e_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             xm_q, xm_d;
    op_t              op_q, op_d;
    logic [11:0]      total_q, total_d;
    logic             zero_q, zero_d;

    logic [IW-1:0]    idx_m1;
    logic [11:0]      total_inc;

    assign idx_m1    = idx_q - 1'b1;
    assign total_inc = (total_q == 12'hFFF) ? total_q : total_q + 12'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            e_q     <= '0;
            idx_q   <= IDX_TOP;
            xm_q    <= 1'b0;
            op_q    <= OPXX;
            total_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            idx_q   <= idx_d;
            xm_q    <= xm_d;
            op_q    <= op_d;
            total_q <= total_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        e_d     = e_q;
        idx_d   = idx_q;
        xm_d    = xm_q;
        op_d    = op_q;
        total_d = total_q;
        zero_d  = zero_q;

        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        e_d     = exp;
                        idx_d   = IDX_TOP;
                        total_d = '0;
                        zero_d  = 1'b0;
                        state_d = S_SCAN;
                    end
                end
                S_SCAN: begin
                    // The leading one itself needs no op: the accumulator already holds M_bar.
                    if (!e_q[idx_q]) begin
                        if (idx_q != '0) begin
                            idx_d = idx_m1;
                        end else begin
                            zero_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    end else if (idx_q == '0) begin
                        op_d    = OPX1;
                        state_d = S_FINAL;
                    end else begin
                        idx_d   = idx_m1;
                        op_d    = OPXX;
                        xm_d    = e_q[idx_m1];
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    total_d = total_inc;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (mp_stop) begin
                        if (xm_q) begin
                            op_d    = OPXM;
                            xm_d    = 1'b0;
                            state_d = S_ISSUE;
                        end else if (idx_q != '0) begin
                            idx_d   = idx_m1;
                            op_d    = OPXX;
                            xm_d    = e_q[idx_m1];
                            state_d = S_ISSUE;
                        end else begin
                            op_d    = OPX1;
                            state_d = S_FINAL;
                        end
                    end
                end
                S_FINAL: begin
                    total_d = total_inc;
                    state_d = S_FWAIT;
                end
                S_FWAIT: begin
                    if (mp_stop) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign mp_start = (state_q == S_ISSUE) || (state_q == S_FINAL);
    assign mp_op    = op_q;
    assign mp_count = MPC10;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign zero_exp = zero_q;
    assign op_total = total_q;

endmodule

// File: doc/mod_exp_ctrl.md
MOD_EXP_CTRL -- requirements
Module: mod_exp_ctrl

Interface
REQ-001 SHALL have parameter EBITS, default 1024: exponent width in bits (power of 2, >=4).
REQ-002 SHALL have parameter MP_COUNT, default 1024: iteration count handed to the Montgomery product engine.
REQ-003 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port go, input, 1: host request; sampled only in IDLE.
REQ-006 SHALL have port exp, input, EBITS: exponent; latched on an accepted go.
REQ-007 SHALL have port abort, input, 1: cancel a run in progress.
REQ-008 SHALL have port mp_start, output, 1: one-cycle start pulse to the product engine.
REQ-009 SHALL have port mp_op, output, 2: opcode: 0=OPXX (x*x), 1=OPXM (x*M), 2=OPX1 (x*1).
REQ-010 SHALL have port mp_count, output, 10: constant MP_COUNT[9:0].
REQ-011 SHALL have port mp_stop, input, 1: engine completion level; high once the result is stored, low from the cycle after mp_start.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse at run end.
REQ-014 SHALL have port zero_exp, output, 1: valid with done; high when the latched exp was 0.
REQ-015 SHALL have port op_total, output, 12: number of mp_start pulses issued in the current or last run.

Function
REQ-016 SHALL implement states IDLE, SCAN, ISSUE, WAIT, FINAL, FWAIT, DONE.
REQ-017 IDLE: on go=1, latch exp into shift register E, set bit index idx=EBITS-1, clear op_total, go to SCAN next cycle.
REQ-018 SCAN (leading-zero skip): one bit per cycle, MSB first; on E[idx]=0 with idx>0, decrement idx; on E[idx]=0 with idx=0, go to DONE with zero_exp=1; on E[idx]=1 (leading one, accumulator already holds M_bar), issue no op; if idx=0 go to FINAL, else decrement idx, set pending={OPXX, then OPXM if E[idx-1]}, go to ISSUE.
REQ-019 For each bit below the leading one, SHALL issue OPXX, then OPXM only if that bit is 1, strictly in that order.
REQ-020 ISSUE: assert mp_start=1 with mp_op valid for exactly one cycle, increment op_total, go to WAIT.
REQ-021 WAIT: hold mp_start=0 and mp_op stable until mp_stop=1; mp_stop is not sampled in ISSUE, since a stale high from the previous op is ignored.
REQ-022 On mp_stop=1 in WAIT: if an OPXM is pending for the current bit, go to ISSUE with mp_op=1; else if idx>0, decrement idx and go to ISSUE with mp_op=0; else go to FINAL.
REQ-023 FINAL: pulse mp_start with mp_op=2 (exit Montgomery domain), increment op_total, go to FWAIT; on mp_stop=1, go to DONE.
REQ-024 DONE: done=1 for one cycle, then IDLE; zero_exp holds its value until the next accepted go.
REQ-025 abort=1 in any non-IDLE state SHALL return to IDLE next cycle with no done pulse; an engine op already started is not recalled, and the next run's first WAIT still requires a fresh mp_stop after its own mp_start.
REQ-026 go while busy SHALL be ignored; abort in IDLE SHALL be ignored; abort takes priority over mp_stop in the same cycle.
REQ-027 op_total SHALL saturate at 4095; for a nonzero exp, final count = 2*(L-1) - ... expressed as (L-1) + (ones-1) + 1, where L = position of the leading one + 1.
REQ-028 mp_op SHALL hold its last value when idle; mp_count SHALL never change.

Reset
REQ-029 rst=1 SHALL force IDLE, mp_start=0, mp_op=0, busy=0, done=0, zero_exp=0, op_total=0, idx=EBITS-1, E=0, immediately and independent of clk, including mid-run.
REQ-030 The first go after rst deasserts SHALL be accepted on the next rising edge.

Verification (EBITS=8, engine model returns mp_stop 5 cycles after mp_start)
REQ-031 exp=8'b1011 -> ops OPXX, OPXX, OPXM, OPXX, OPXM, OPX1; op_total=6; done once; zero_exp=0.
REQ-032 exp=0 -> 8 SCAN cycles, no mp_start, done pulse with zero_exp=1, op_total=0.
REQ-033 exp=8'h01 -> only OPX1 issued; op_total=1. exp=8'hFF -> 7 OPXX, 7 OPXM interleaved, then OPX1; op_total=15.
REQ-034 exp=8'h80, abort raised in the 3rd WAIT -> IDLE next cycle, no done; a new go with exp=8'h03 completes with op_total=3.
REQ-035 rst pulsed mid-WAIT -> all outputs at reset values before the next clk edge; a stale mp_stop=1 held during ISSUE of the next run is not taken as completion.
REQ-036 go held high through a whole run -> exactly one run starts per entry into IDLE; go pulses while busy have no effect.
